// File: rtl/mem_access_stage.sv
// MEM-stage access unit: EX/MEM -> data-memory req/ack handshake, pipeline stall, branch resolve, MEM/WB registers.
// Optional misaligned-access trap is enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              MemRead_In,
   input  logic              MemWrite_In,
   input  logic              Branch_In,
   input  logic              ALUZero_In,
   input  logic              RegWrite_In,
   input  logic              MemToReg_In,
   input  logic [31:0]       ALUResult_In,
   input  logic [31:0]       RegisterRead2_In,
   input  logic [31:0]       AdderResult_In,
   input  logic [4:0]        WriteReg_In,
   output logic              DMemReq,
   output logic              DMemWe,
   output logic [ADDR_W-1:0] DMemAddr,
   output logic [DATA_W-1:0] DMemWData,
   input  logic [DATA_W-1:0] DMemRData,
   input  logic              DMemAck,
   output logic              Stall,
   output logic              PCSrc,
   output logic [31:0]       BranchTarget,
   output logic [31:0]       ReadData_Out,
   output logic [31:0]       ALUResult_Out,
   output logic [4:0]        WriteReg_Out,
   output logic              RegWrite_Out,
   output logic              MemToReg_Out,
   output logic              MisalignFault_Out
);
   typedef enum logic {IDLE, ACCESS} state_t;

   typedef struct packed {
      logic [31:0] aluResult;
      logic [4:0]  writeReg;
      logic        regWrite;
      logic        memToReg;
   } wbFields_t;

   state_t            state;
   wbFields_t         wbHold;
   logic              memOp;
   logic              misalign;
   logic              issue;
   logic [ADDR_W-1:0] reqAddr;

   assign memOp = MemRead_In | MemWrite_In;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misalign = memOp & (ALUResult_In[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   // Word accesses only: low address bits never reach the memory.
   assign reqAddr      = ADDR_W'(ALUResult_In) & ~ADDR_W'(3);
   assign issue        = (state == IDLE) & memOp & ~misalign;
   assign Stall        = issue | ((state == ACCESS) & ~DMemAck);
   assign PCSrc        = Branch_In & ALUZero_In & ~Stall;
   assign BranchTarget = AdderResult_In;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         wbHold        <= '0;
         DMemReq       <= 1'b0;
         DMemWe        <= 1'b0;
         DMemAddr      <= '0;
         DMemWData     <= '0;
         ReadData_Out  <= '0;
         ALUResult_Out <= '0;
         WriteReg_Out  <= '0;
         RegWrite_Out  <= 1'b0;
         MemToReg_Out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  state        <= ACCESS;
                  DMemReq      <= 1'b1;
                  DMemWe       <= MemWrite_In;
                  DMemAddr     <= reqAddr;
                  DMemWData    <= DATA_W'(RegisterRead2_In);
                  wbHold       <= '{ALUResult_In, WriteReg_In, RegWrite_In, MemToReg_In};
                  RegWrite_Out <= 1'b0;
                  MemToReg_Out <= 1'b0;
               end else if (misalign) begin
                  RegWrite_Out <= 1'b0;
                  MemToReg_Out <= 1'b0;
               end else begin
                  ALUResult_Out <= ALUResult_In;
                  WriteReg_Out  <= WriteReg_In;
                  RegWrite_Out  <= RegWrite_In;
                  MemToReg_Out  <= MemToReg_In;
               end
            end
            ACCESS: begin
               if (DMemAck) begin
                  state         <= IDLE;
                  ReadData_Out  <= DMemWe ? 32'h0 : 32'(DMemRData);
                  ALUResult_Out <= wbHold.aluResult;
                  WriteReg_Out  <= wbHold.writeReg;
                  RegWrite_Out  <= wbHold.regWrite;
                  MemToReg_Out  <= wbHold.memToReg;
                  DMemReq       <= 1'b0;
                  DMemWe        <= 1'b0;
                  DMemAddr      <= '0;
                  DMemWData     <= '0;
               end else begin
                  RegWrite_Out <= 1'b0;
                  MemToReg_Out <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic faultQ;
   always_ff @(posedge Clk) begin
      if (Reset) faultQ <= 1'b0;
      else       faultQ <= (state == IDLE) & misalign;
   end
   assign MisalignFault_Out = faultQ;
`else
   assign MisalignFault_Out = 1'b0;
`endif

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage access unit that consumes the EX/MEM pipeline register outputs and runs the data-memory transaction they describe. It issues a request/acknowledge handshake to a variable-latency data memory, stalls the upstream pipeline until the access completes, resolves branch selection, and registers results toward MEM/WB. It sits between the EX/MEM register and the data memory / MEM/WB register.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data width

Ports:
- Clk  in  1  clock; all state changes on posedge
- Reset  in  1  synchronous, active-high reset
- MemRead_In, MemWrite_In, Branch_In, ALUZero_In, RegWrite_In, MemToReg_In  in  1 each  control fields from EX/MEM
- ALUResult_In  in  32  effective address / ALU result
- RegisterRead2_In  in  32  store data
- AdderResult_In  in  32  branch target
- WriteReg_In  in  5  destination register
- DMemReq  out  1  request valid (registered)
- DMemWe  out  1  1 = write, 0 = read
- DMemAddr  out  ADDR_W  access address
- DMemWData  out  DATA_W  write data
- DMemRData  in  DATA_W  read data, valid with DMemAck
- DMemAck  in  1  single-cycle completion strobe
- Stall  out  1  hold EX/MEM and upstream stages
- PCSrc  out  1  branch taken
- BranchTarget  out  32  branch destination
- ReadData_Out, ALUResult_Out  out  32  registered to MEM/WB
- WriteReg_Out  out  5  registered
- RegWrite_Out, MemToReg_Out  out  1  registered
- MisalignFault_Out  out  1  one-cycle fault pulse (see Configuration)

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, no memory op: inputs pass through; WB outputs register at the next edge; stay in IDLE.
- IDLE, MemRead_In or MemWrite_In: latch address, write data, direction, and WB fields. Go to ACCESS; DMemReq=1 from the next cycle. MemWrite has priority if both are set.
- ACCESS: hold DMemReq, DMemWe, DMemAddr, and DMemWData stable until DMemAck. On ack: capture DMemRData into ReadData_Out (0 for writes), register the WB fields, drop DMemReq at that edge, return to IDLE.
- Stall = (IDLE and memory op) or (ACCESS and not DMemAck). The formula is combinational.
- While Stall=1, WB registers load a bubble: RegWrite_Out=0, MemToReg_Out=0.
- PCSrc = Branch_In & ALUZero_In & ~Stall. BranchTarget = AdderResult_In. Both are combinational.
- DMemAck outside ACCESS is ignored.

## Timing
- Reset: state IDLE; DMemReq, DMemWe, DMemAddr, DMemWData, ReadData_Out, ALUResult_Out, WriteReg_Out, RegWrite_Out, MemToReg_Out, and MisalignFault_Out all 0.
- Non-memory instruction: 1 cycle to WB outputs, no stall.
- Memory instruction: 2 + N cycles, where N is the number of ACCESS cycles without ack. Zero-wait memory (ack in the first ACCESS cycle) gives 2 cycles and Stall high for 1 cycle.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle after the ack edge. At most one outstanding request.
- Reset mid-ACCESS: return to IDLE and drop DMemReq at that edge. The late ack is ignored, and the memory abandons the request.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined: a memory op in IDLE with ALUResult_In[1:0] != 0 issues no request and asserts no Stall. It pulses MisalignFault_Out=1 for one cycle and loads a WB bubble.
- Undefined: DMemAddr[1:0] is forced to 00 and the access proceeds normally; MisalignFault_Out is tied 0.

## Test plan
- Reset, then ALU op (ALUResult_In=0x1234, RegWrite_In=1, WriteReg_In=5) -> next cycle ALUResult_Out=0x1234, RegWrite_Out=1, WriteReg_Out=5, Stall never 1.
- Load at 0x40, ack 3 cycles after DMemReq rises with DMemRData=0xDEADBEEF -> Stall high 4 cycles, then ReadData_Out=0xDEADBEEF, MemToReg_Out=1, DMemReq low.
- Store 0xCAFEF00D to 0x80, zero-wait ack -> DMemWe=1, DMemWData=0xCAFEF00D for exactly 1 cycle, Stall high 1 cycle, RegWrite_Out=0.
- Branch_In=1, ALUZero_In=1, AdderResult_In=0x100 -> PCSrc=1, BranchTarget=0x100. Same inputs with ALUZero_In=0 -> PCSrc=0.
- Reset asserted 2 cycles into an unacknowledged load, then ack -> DMemReq 0 after the reset edge, state IDLE, ack ignored, all outputs 0.
- Macro on, load at 0x42 -> MisalignFault_Out pulses 1 cycle, DMemReq stays 0, RegWrite_Out=0. Macro off -> DMemAddr=0x40.
